// File: rtl/rop_frag_serializer.sv
// rop_frag_serializer
//   Input stage of the ROP unit. Warp-wide requests (thread mask plus per-lane
//   position/color/depth/backface) are queued in a small FIFO and then split
//   into one single-fragment transaction per active lane, lowest lane first.
//   Fragments go on to the depth/stencil test stage.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   req_*                 : request channel (tmask + flat per-lane vectors)
//   frag_*                : fragment channel (selected lane's data, lane index,
//                           last-of-request flag)
//   perf_reqs/frags/stalls: event counters, present only when the macro
//                           ROP_FRAG_PERF_EN is defined (tied to 0 otherwise)
//   dbg_state             : serializer state (0 = IDLE, 1 = EMIT)
//
// Handshake: on both channels a transfer happens on a rising edge where
// valid && ready. A producer holds valid and its data stable until the
// transfer; ready never depends combinationally on the same channel's valid.
module rop_frag_serializer #(
  parameter int NUM_LANES  = 4,
  parameter int QUEUE_SIZE = 4,
  parameter int DIM_BITS   = 12,
  parameter int DEPTH_BITS = 24,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [NUM_LANES-1:0]             req_tmask,
  input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_y,
  input  logic [NUM_LANES*32-1:0]          req_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0]  req_depth,
  input  logic [NUM_LANES-1:0]             req_backface,
  output logic                             frag_valid,
  input  logic                             frag_ready,
  output logic [DIM_BITS-1:0]              frag_pos_x,
  output logic [DIM_BITS-1:0]              frag_pos_y,
  output logic [31:0]                      frag_color,
  output logic [DEPTH_BITS-1:0]            frag_depth,
  output logic                             frag_backface,
  output logic [LANE_W-1:0]                frag_lane,
  output logic                             frag_last,
  output logic [31:0]                      perf_reqs,
  output logic [31:0]                      perf_frags,
  output logic [31:0]                      perf_stalls,
  output logic                             dbg_state
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  // Request FIFO storage (data only, no reset needed)
  logic [NUM_LANES-1:0]            q_tmask    [QUEUE_SIZE];
  logic [NUM_LANES*DIM_BITS-1:0]   q_pos_x    [QUEUE_SIZE];
  logic [NUM_LANES*DIM_BITS-1:0]   q_pos_y    [QUEUE_SIZE];
  logic [NUM_LANES*32-1:0]         q_color    [QUEUE_SIZE];
  logic [NUM_LANES*DEPTH_BITS-1:0] q_depth    [QUEUE_SIZE];
  logic [NUM_LANES-1:0]            q_backface [QUEUE_SIZE];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             fifo_empty, fifo_full, push, pop;

  // Current entry being serialized
  state_t                          state;
  logic [NUM_LANES-1:0]            rem_mask;
  logic [NUM_LANES*DIM_BITS-1:0]   cur_pos_x, cur_pos_y;
  logic [NUM_LANES*32-1:0]         cur_color;
  logic [NUM_LANES*DEPTH_BITS-1:0] cur_depth;
  logic [NUM_LANES-1:0]            cur_backface;

  logic [LANE_W-1:0]    lane_sel;
  logic [NUM_LANES-1:0] rem_next;
  logic                 last_frag, fire;

  assign wr_idx     = wr_ptr[PTR_W-1:0];
  assign rd_idx     = rd_ptr[PTR_W-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

  // A full FIFO refuses the push even if it is popped this same cycle
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  assign frag_valid = (state == S_EMIT);
  assign fire       = frag_valid && frag_ready;
  assign dbg_state  = (state == S_EMIT);

  // Clearing the lowest set bit: x & (x - 1)
  assign rem_next  = rem_mask & (rem_mask - NUM_LANES'(1));
  assign last_frag = (rem_next == '0);
  assign frag_last = frag_valid && last_frag;
  assign frag_lane = lane_sel;

  // Pop from IDLE whenever something is queued, or on the final handshake of
  // the current entry so consecutive requests stream without a bubble.
  assign pop = !fifo_empty && ((state == S_IDLE) || (fire && last_frag));

  // Lowest set bit of rem_mask (descending scan so the lowest wins)
  always_comb begin
    lane_sel = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rem_mask[i]) lane_sel = LANE_W'(i);
    end
  end

  always_comb begin
    frag_pos_x    = '0;
    frag_pos_y    = '0;
    frag_color    = '0;
    frag_depth    = '0;
    frag_backface = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_sel == LANE_W'(i)) begin
        frag_pos_x    = cur_pos_x[i*DIM_BITS +: DIM_BITS];
        frag_pos_y    = cur_pos_y[i*DIM_BITS +: DIM_BITS];
        frag_color    = cur_color[i*32 +: 32];
        frag_depth    = cur_depth[i*DEPTH_BITS +: DEPTH_BITS];
        frag_backface = cur_backface[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_tmask[wr_idx]    <= req_tmask;
      q_pos_x[wr_idx]    <= req_pos_x;
      q_pos_y[wr_idx]    <= req_pos_y;
      q_color[wr_idx]    <= req_color;
      q_depth[wr_idx]    <= req_depth;
      q_backface[wr_idx] <= req_backface;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= S_IDLE;
      rem_mask     <= '0;
      cur_pos_x    <= '0;
      cur_pos_y    <= '0;
      cur_color    <= '0;
      cur_depth    <= '0;
      cur_backface <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + (PTR_W+1)'(1);
        rem_mask     <= q_tmask[rd_idx];
        cur_pos_x    <= q_pos_x[rd_idx];
        cur_pos_y    <= q_pos_y[rd_idx];
        cur_color    <= q_color[rd_idx];
        cur_depth    <= q_depth[rd_idx];
        cur_backface <= q_backface[rd_idx];
        // An empty-mask request is consumed without emitting anything
        state        <= (q_tmask[rd_idx] != '0) ? S_EMIT : S_IDLE;
      end else if (fire) begin
        rem_mask <= rem_next;
        if (last_frag) state <= S_IDLE;
      end
    end
  end

`ifdef ROP_FRAG_PERF_EN
  logic [31:0] perf_reqs_q, perf_frags_q, perf_stalls_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reqs_q   <= '0;
      perf_frags_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (push)                       perf_reqs_q   <= perf_reqs_q + 32'd1;
      if (fire)                       perf_frags_q  <= perf_frags_q + 32'd1;
      if (frag_valid && !frag_ready)  perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_reqs   = perf_reqs_q;
  assign perf_frags  = perf_frags_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_reqs   = '0;
  assign perf_frags  = '0;
  assign perf_stalls = '0;
`endif

endmodule
